data_cache: RTL and testbench
=============================

DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter NUM_LINES, default 8, number of direct-mapped lines (power of two).
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line; the line is 128 bits.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 proc_ren  input  1  processor read request.
REQ-006 proc_wen  input  1  processor write request; has priority when asserted together with proc_ren.
REQ-007 proc_addr  input  30  word address: [1:0] word offset, [4:2] index, [29:5] tag.
REQ-008 proc_wdata  input  32  write data.
REQ-009 proc_stall  output  1  high while the current request cannot complete this cycle.
REQ-010 proc_rdata  output  32  read data, valid when proc_ren=1 and proc_stall=0.
REQ-011 mem_read  output  1  line-fill request to memory.
REQ-012 mem_write  output  1  line write-back request to memory.
REQ-013 mem_addr  output  28  line address {tag, index}.
REQ-014 mem_wdata  output  128  victim line; word 0 sits in [31:0].
REQ-015 mem_rdata  input  128  fill line; same word order as mem_wdata.
REQ-016 mem_ready  input  1  one-cycle pulse; the memory transaction completes this cycle.

Function
REQ-017 Per line the block SHALL hold: valid bit, dirty bit, 25-bit tag, 128-bit data.
REQ-018 Hit SHALL mean: line[index].valid and line[index].tag == proc_addr[29:5].
REQ-019 FSM states SHALL be IDLE, WRITEBACK and ALLOCATE.
REQ-020 IDLE, no request: proc_stall=0, mem_read=0, mem_write=0.
REQ-021 IDLE, read hit: proc_stall=0; proc_rdata = selected word, combinationally in the same cycle; no state change.
REQ-022 IDLE, write hit: proc_stall=0; on the clock edge the selected word <= proc_wdata and dirty <= 1.
REQ-023 IDLE, miss with the victim clean or invalid: proc_stall=1; next state ALLOCATE.
REQ-024 IDLE, miss with the victim valid and dirty: proc_stall=1; next state WRITEBACK.
REQ-025 WRITEBACK outputs: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim data, proc_stall=1.
REQ-026 WRITEBACK exit: on mem_ready, dirty <= 0 and next state ALLOCATE.
REQ-027 ALLOCATE outputs: mem_read=1, mem_addr=proc_addr[29:2], proc_stall=1.
REQ-028 ALLOCATE exit: on mem_ready, data <= mem_rdata, tag <= request tag, valid <= 1, dirty <= 0, next state IDLE.
REQ-029 Completion of a miss: the request SHALL be re-evaluated in IDLE and hit; write data merges in that cycle. Minimum miss penalty is 2 cycles of stall plus memory latency.
REQ-030 mem_read and mem_write SHALL never be high together.
REQ-031 Both signals SHALL be held stable until mem_ready.
REQ-032 proc_addr, proc_wdata, proc_ren and proc_wen SHALL be assumed stable while proc_stall=1.
REQ-033 mem_ready received in IDLE SHALL be ignored.
REQ-034 Index wrap: any two addresses sharing [4:2] but differing in tag SHALL evict each other.
REQ-035 Don't-care outputs: proc_rdata is don't-care when not a read hit; mem_wdata and mem_addr are don't-care when neither mem_read nor mem_write is high.

Reset
REQ-036 While rst_n=0 at a clock edge: state <= IDLE, all valid <= 0, all dirty <= 0.
REQ-037 Output values in that reset cycle: proc_stall=0 unless a request is present, mem_read=0, mem_write=0.
REQ-038 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abort the transaction; dirty data is lost.
REQ-039 Tag and data arrays need no reset.

Structure
REQ-040 A shared package SHALL hold: the state encoding (IDLE/WRITEBACK/ALLOCATE), the TAG_W=25, IDX_W=3 and OFF_W=2 constants, and the line width of 128.
REQ-041 One sub-module, cache_line_sel, SHALL be used: a combinational 128-to-32 word selector and word-merge-on-write.

Verification
REQ-042 Cold read miss: reset, then proc_ren=1, proc_addr=0x0000_0004. Required: mem_read=1, mem_addr=0x000_0001, 0 writes. Memory returns 128'h...DDDD_CCCC_BBBB_AAAA after 5 cycles, then proc_stall=0 and proc_rdata=0xAAAA.
REQ-043 Write hit, then read: write 0x1234_5678 to addr 0x05, no stall. A following read of 0x05 returns 0x1234_5678 with no stall and no memory traffic.
REQ-044 Dirty eviction: after REQ-043, read addr 0x25 (same index, tag 1). Required: mem_write=1 with mem_addr=0x000_0001 and mem_wdata[63:32]=0x1234_5678, then mem_read=1 with mem_addr=0x000_0009.
REQ-045 Back-to-back hits: 8 consecutive reads across all indices after warm-up. Required: proc_stall=0 on every cycle.
REQ-046 Reset in ALLOCATE: assert rst_n=0 while mem_read=1. Required: mem_read=0 in the next cycle, and a subsequent read of the same address misses again.
REQ-047 Slow memory: mem_ready is delayed 20 cycles in WRITEBACK. Required: mem_addr and mem_wdata are stable, and mem_read stays 0 throughout.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped write-back data cache.
// Address split is {tag, index, word offset} on a 30-bit word address.
package data_cache_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    localparam int TAG_W   = 25;
    localparam int IDX_W   = 3;
    localparam int OFF_W   = 2;
    localparam int WORD_W  = 32;
    localparam int LINE_W  = 128;
    localparam int ADDR_W  = TAG_W + IDX_W + OFF_W;
    localparam int MADDR_W = TAG_W + IDX_W;
endpackage

// File: rtl/data_cache_if.sv
// Processor-side and memory-side signals of the data cache in one bundle.
// The cache takes the slave view; the processor/memory environment takes the master view.
interface data_cache_if;
    import data_cache_pkg::*;

    logic                proc_ren;
    logic                proc_wen;
    logic [ADDR_W-1:0]   proc_addr;
    logic [WORD_W-1:0]   proc_wdata;
    logic                proc_stall;
    logic [WORD_W-1:0]   proc_rdata;
    logic                mem_read;
    logic                mem_write;
    logic [MADDR_W-1:0]  mem_addr;
    logic [LINE_W-1:0]   mem_wdata;
    logic [LINE_W-1:0]   mem_rdata;
    logic                mem_ready;

    modport slave (
        input  proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_ren, proc_wen, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_line_sel.sv
// Combinational word access into one cache line: selects the addressed word
// and builds the line with that word replaced by the write data.
module cache_line_sel #(
    parameter int WORDS = 4
) (
    input  logic [WORDS*32-1:0]       i_line,
    input  logic [$clog2(WORDS)-1:0]  i_off,
    input  logic [31:0]               i_wdata,
    output logic [31:0]               o_rdata,
    output logic [WORDS*32-1:0]       o_line
);
    assign o_rdata = i_line[i_off*32 +: 32];

    always_comb begin
        o_line = i_line;
        o_line[i_off*32 +: 32] = i_wdata;
    end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with a blocking
// IDLE -> WRITEBACK -> ALLOCATE miss sequence; hits complete combinationally.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    data_cache_if.slave  bus
);
    state_t               r_state;
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];
    logic                 r_mem_read;
    logic                 r_mem_write;

    logic [TAG_W-1:0]     w_tag;
    logic [IDX_W-1:0]     w_idx;
    logic [OFF_W-1:0]     w_off;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_wr_hit;
    logic [WORD_W-1:0]    w_word;
    logic [LINE_W-1:0]    w_merged;

    assign w_tag    = bus.proc_addr[ADDR_W-1:IDX_W+OFF_W];
    assign w_idx    = bus.proc_addr[IDX_W+OFF_W-1:OFF_W];
    assign w_off    = bus.proc_addr[OFF_W-1:0];
    assign w_req    = bus.proc_ren | bus.proc_wen;
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss   = w_req && !w_hit;
    assign w_wr_hit = (r_state == IDLE) && bus.proc_wen && w_hit;

    cache_line_sel #(.WORDS(WORDS_PER_LINE)) u_sel (
        .i_line  (r_data[w_idx]),
        .i_off   (w_off),
        .i_wdata (bus.proc_wdata),
        .o_rdata (w_word),
        .o_line  (w_merged)
    );

    // Reset masks the busy state combinationally so an aborted transfer drops at once.
    assign bus.proc_stall = (rst_n && (r_state != IDLE)) || w_miss;
    assign bus.proc_rdata = w_word;
    assign bus.mem_read   = r_mem_read  && rst_n;
    assign bus.mem_write  = r_mem_write && rst_n;
    assign bus.mem_addr   = (r_state == WRITEBACK) ? {r_tag[w_idx], w_idx}
                                                   : bus.proc_addr[ADDR_W-1:OFF_W];
    assign bus.mem_wdata  = r_data[w_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state     <= WRITEBACK;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state     <= ALLOCATE;
                            r_mem_read  <= 1'b1;
                        end
                    end else if (w_wr_hit) begin
                        r_dirty[w_idx] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= ALLOCATE;
                        r_mem_write    <= 1'b0;
                        r_mem_read     <= 1'b1;
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        r_valid[w_idx] <= 1'b1;
                        r_dirty[w_idx] <= 1'b0;
                        r_state        <= IDLE;
                        r_mem_read     <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays carry no reset; valid bits alone qualify them.
    always_ff @(posedge clk) begin
        if ((r_state == ALLOCATE) && bus.mem_ready) begin
            r_data[w_idx] <= bus.mem_rdata;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx] <= w_merged;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus random traffic
// checked against an abstract cache-contents model and a backing memory map.
module tb_data_cache;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    data_cache_if bus();

    data_cache #(.NUM_LINES(8), .WORDS_PER_LINE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: what each line should hold, and what main memory holds.
    bit           m_valid [8];
    bit           m_dirty [8];
    logic [24:0]  m_tag   [8];
    logic [127:0] m_line  [8];
    logic [127:0] mem_lines [logic [27:0]];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] line_val(input logic [27:0] la);
        logic [127:0] v;
        if (mem_lines.exists(la)) return mem_lines[la];
        for (int k = 0; k < 4; k++) v[k*32 +: 32] = {la, 2'(k), 2'b01};
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) begin
            m_valid[k] = 1'b0;
            m_dirty[k] = 1'b0;
        end
    endtask

    // One memory transaction: lat idle cycles, then a one-cycle mem_ready.
    task automatic serve(input bit is_wr, input logic [27:0] ea, input logic [127:0] ewd,
                         input logic [127:0] rdat, input int lat);
        bus.mem_rdata = rdat;
        for (int c = 0; c <= lat; c++) begin
            if (c == lat) bus.mem_ready = 1'b1;
            @(negedge clk);
            chk("mem_write", bus.mem_write, is_wr);
            chk("mem_read", bus.mem_read, !is_wr);
            chk("mem_addr", bus.mem_addr, ea);
            if (is_wr) chk("mem_wdata", bus.mem_wdata, ewd);
            chk("busy_stall", bus.proc_stall, 1'b1);
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic access(input bit wr, input bit also_rd, input logic [29:0] a,
                          input logic [31:0] wd, input int lat);
        logic [24:0]  t;
        int           i;
        int           w;
        bit           hit;
        logic [127:0] fill;
        t   = a[29:5];
        i   = int'(a[4:2]);
        w   = int'(a[1:0]);
        hit = m_valid[i] && (m_tag[i] == t);
        bus.proc_wen   = wr;
        bus.proc_ren   = !wr || also_rd;
        bus.proc_addr  = a;
        bus.proc_wdata = wd;
        if (!hit) begin
            @(negedge clk);
            chk("miss_stall", bus.proc_stall, 1'b1);
            chk("miss_idle_mem", {bus.mem_read, bus.mem_write}, 2'b00);
            @(posedge clk); #1;
            if (m_valid[i] && m_dirty[i]) begin
                serve(1'b1, {m_tag[i], 3'(i)}, m_line[i], '0, lat);
                mem_lines[{m_tag[i], 3'(i)}] = m_line[i];
                m_dirty[i] = 1'b0;
            end
            fill = line_val(a[29:2]);
            serve(1'b0, a[29:2], '0, fill, lat);
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_line[i]  = fill;
        end
        @(negedge clk);
        chk("hit_stall", bus.proc_stall, 1'b0);
        if (!wr) chk("rdata", bus.proc_rdata, m_line[i][w*32 +: 32]);
        chk("hit_no_mem", {bus.mem_read, bus.mem_write}, 2'b00);
        @(posedge clk); #1;
        if (wr) begin
            m_line[i][w*32 +: 32] = wd;
            m_dirty[i] = 1'b1;
        end
        bus.proc_ren = 1'b0;
        bus.proc_wen = 1'b0;
    endtask

    initial begin
        logic [29:0] ra;
        rst_n          = 1'b0;
        bus.proc_ren   = 1'b0;
        bus.proc_wen   = 1'b0;
        bus.proc_addr  = '0;
        bus.proc_wdata = '0;
        bus.mem_rdata  = '0;
        bus.mem_ready  = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", bus.proc_stall, 1'b0);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_mem_write", bus.mem_write, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Cold read miss with a 5-cycle memory.
        mem_lines[28'h1] = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
        access(1'b0, 1'b0, 30'h4, '0, 5);
        chk("cold_rdata_const", m_line[1][31:0], 32'h0000AAAA);

        // Write hit then read back.
        access(1'b1, 1'b0, 30'h5, 32'h1234_5678, 0);
        access(1'b0, 1'b0, 30'h5, '0, 0);

        // Dirty eviction on the same index, with a slow write-back.
        chk("evict_victim_word", m_line[1][63:32], 32'h1234_5678);
        access(1'b0, 1'b0, 30'h25, '0, 20);
        chk("wb_stored", mem_lines[28'h1][63:32], 32'h1234_5678);

        // mem_ready while idle must be ignored.
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("idle_rdy_stall", bus.proc_stall, 1'b0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("idle_rdy_mem", {bus.mem_read, bus.mem_write}, 2'b00);
        @(posedge clk); #1;

        // Warm all indices, then eight back-to-back hits.
        for (int k = 0; k < 8; k++) access(1'b0, 1'b0, 30'(k * 4), '0, 1);
        for (int k = 0; k < 8; k++) access(1'b0, 1'b0, 30'(k * 4 + (k % 4)), '0, 0);

        // Reset while allocating aborts the fill.
        bus.proc_ren  = 1'b1;
        bus.proc_addr = 30'h100;
        @(negedge clk);
        chk("abort_miss_stall", bus.proc_stall, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_alloc_read", bus.mem_read, 1'b1);
        chk("abort_alloc_addr", bus.mem_addr, 28'h40);
        @(posedge clk); #1;
        rst_n        = 1'b0;
        bus.proc_ren = 1'b0;
        @(negedge clk);
        chk("abort_rst_read", bus.mem_read, 1'b0);
        chk("abort_rst_stall", bus.proc_stall, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("abort_after_read", bus.mem_read, 1'b0);
        chk("abort_after_write", bus.mem_write, 1'b0);
        @(posedge clk); #1;
        access(1'b0, 1'b0, 30'h100, '0, 2);

        // Random traffic over a few tags so hits, clean and dirty evictions mix.
        for (int n = 0; n < 80; n++) begin
            ra = {23'd0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
